// File: rtl/uart_rx_cfg_pkg.sv
// Shared encodings for the configurable UART receiver: parity modes,
// receiver state names and configuration limits.
package uart_rx_cfg_pkg;

  // Parity mode encodings as seen on cfg_parity (3 also means none).
  localparam logic [1:0] UART_PARITY_NONE = 2'd0;
  localparam logic [1:0] UART_PARITY_EVEN = 2'd1;
  localparam logic [1:0] UART_PARITY_ODD  = 2'd2;

  // Smallest divisor that still leaves room for three samples plus a vote.
  localparam int UART_RX_MIN_DIVISOR  = 4;
  localparam int UART_RX_MIN_DATABITS = 5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_e;

  // True when the latched mode carries a parity bit.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == UART_PARITY_EVEN) || (mode == UART_PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// Line conditioning for the receiver: 2-FF synchroniser, falling-edge
// detect, per-bit counter and 3-sample majority vote.
module uart_rx_cfg_sampler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_pin,
  input  logic [DIV_W-1:0] divisor,
  input  logic             restart,
  output logic             start_edge,
  output logic             bit_strobe,
  output logic             bit_value,
  output logic             line_level
);

  logic             sync1;
  logic             sync2;
  logic             line_d;
  logic [1:0]       fill;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half;
  logic             samp0;
  logic             samp1;

  assign half = divisor >> 1;

  // Synchroniser and edge history. line_d is held low until the
  // synchroniser holds real pin samples, so a line that is low coming out
  // of reset never looks like a 1->0 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      fill   <= 2'b00;
      line_d <= 1'b0;
    end else begin
      sync1  <= rx_pin;
      sync2  <= sync1;
      fill   <= {fill[0], 1'b1};
      line_d <= fill[1] ? sync2 : 1'b0;
    end
  end

  assign start_edge = line_d & ~sync2;
  assign line_level = sync2;

  // Bit-period counter, realigned to the start edge. Samples are taken
  // from line_d, which lines count 0 up with the first clock of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt >= divisor - DIV_W'(1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (cnt == half - DIV_W'(1)) samp0 <= line_d;
      if (cnt == half)             samp1 <= line_d;
    end
  end

  assign bit_strobe = (cnt == half + DIV_W'(1));
  assign bit_value  = (samp0 & samp1) | (samp0 & line_d) | (samp1 & line_d);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: frame state machine, data assembly,
// parity/framing/break checks and a one-deep output register.
// out_valid/out_ready: a word transfers on every cycle where both are high;
// while out_valid is high and out_ready low, out_data and the flags hold.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_pin,
  input  logic [DIV_W-1:0]  cfg_divisor,
  input  logic [4:0]        cfg_databits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stopbits,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_frame_err,
  output logic              out_parity_err,
  output logic              out_break,
  output logic              overrun,
  output rx_state_e         dbg_state
);

  rx_state_e         state, state_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [4:0]        nbits_q, nbits_n;
  logic [1:0]        par_q, par_n;
  logic              stop2_q, stop2_n;
  logic [4:0]        bit_idx, bit_idx_n;
  logic              stop_idx, stop_idx_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              par_acc, par_acc_n;
  logic              ferr_q, ferr_n;
  logic              perr_q, perr_n;
  logic              brk_q, brk_n;
  logic              word_done;
  logic              start_frame;

  logic              start_edge;
  logic              bit_strobe;
  logic              bit_value;
  logic              line_level;

  logic [DIV_W-1:0]  cfg_div_eff;
  logic [4:0]        cfg_bits_eff;

  assign cfg_div_eff = (cfg_divisor < DIV_W'(UART_RX_MIN_DIVISOR)) ?
                       DIV_W'(UART_RX_MIN_DIVISOR) : cfg_divisor;
  assign cfg_bits_eff = (cfg_databits < 5'(UART_RX_MIN_DATABITS)) ? 5'(UART_RX_MIN_DATABITS) :
                        (cfg_databits > 5'(DATA_W)) ? 5'(DATA_W) : cfg_databits;

  assign dbg_state = state;

  uart_rx_cfg_sampler #(.DIV_W(DIV_W)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (rx_pin),
    .divisor    (div_q),
    .restart    (start_frame),
    .start_edge (start_edge),
    .bit_strobe (bit_strobe),
    .bit_value  (bit_value),
    .line_level (line_level)
  );

  // Frame state and per-frame context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      div_q    <= DIV_W'(UART_RX_MIN_DIVISOR);
      nbits_q  <= 5'(UART_RX_MIN_DATABITS);
      par_q    <= UART_PARITY_NONE;
      stop2_q  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      par_acc  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state    <= state_n;
      div_q    <= div_n;
      nbits_q  <= nbits_n;
      par_q    <= par_n;
      stop2_q  <= stop2_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shift_q  <= shift_n;
      par_acc  <= par_acc_n;
      ferr_q   <= ferr_n;
      perr_q   <= perr_n;
      brk_q    <= brk_n;
    end
  end

  // Next-state and frame datapath. A start edge that lands on the final
  // stop vote (possible at the minimum divisor) starts the next frame
  // directly instead of being lost in IDLE.
  always_comb begin
    state_n     = state;
    div_n       = div_q;
    nbits_n     = nbits_q;
    par_n       = par_q;
    stop2_n     = stop2_q;
    bit_idx_n   = bit_idx;
    stop_idx_n  = stop_idx;
    shift_n     = shift_q;
    par_acc_n   = par_acc;
    ferr_n      = ferr_q;
    perr_n      = perr_q;
    brk_n       = brk_q;
    word_done   = 1'b0;
    start_frame = 1'b0;

    case (state)
      RX_IDLE: begin
        if (start_edge) start_frame = 1'b1;
      end
      RX_START: begin
        if (bit_strobe) begin
          if (bit_value) begin
            state_n = RX_IDLE;
          end else begin
            state_n    = RX_DATA;
            bit_idx_n  = '0;
            stop_idx_n = 1'b0;
            shift_n    = '0;
            par_acc_n  = 1'b0;
            ferr_n     = 1'b0;
            perr_n     = 1'b0;
            brk_n      = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (bit_strobe) begin
          shift_n   = shift_q | (DATA_W'(bit_value) << bit_idx);
          par_acc_n = par_acc ^ bit_value;
          brk_n     = brk_q & ~bit_value;
          if (bit_idx == nbits_q - 5'd1) begin
            state_n = parity_enabled(par_q) ? RX_PARITY : RX_STOP;
          end else begin
            bit_idx_n = bit_idx + 5'd1;
          end
        end
      end
      RX_PARITY: begin
        if (bit_strobe) begin
          perr_n  = (par_acc ^ bit_value) != (par_q == UART_PARITY_ODD);
          brk_n   = brk_q & ~bit_value;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_strobe) begin
          if (!bit_value) ferr_n = 1'b1;
          if (!stop_idx) brk_n = brk_q & ~bit_value;
          if (stop_idx == stop2_q) begin
            word_done = 1'b1;
            if (brk_n) begin
              state_n = RX_BRK_WAIT;
            end else if (start_edge) begin
              start_frame = 1'b1;
            end else begin
              state_n = RX_IDLE;
            end
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      RX_BRK_WAIT: begin
        if (line_level) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase

    if (start_frame) begin
      state_n = RX_START;
      div_n   = cfg_div_eff;
      nbits_n = cfg_bits_eff;
      par_n   = cfg_parity;
      stop2_n = cfg_stopbits;
    end
  end

  // One-deep output register; a word finishing while a held word is
  // unaccepted is dropped and reported through overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_frame_err  <= 1'b0;
      out_parity_err <= 1'b0;
      out_break      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done && (!out_valid || out_ready)) begin
        out_data       <= shift_n;
        out_frame_err  <= ferr_n;
        out_parity_err <= perr_n;
        out_break      <= brk_n;
        out_valid      <= 1'b1;
      end else if (word_done) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
